rr_allocator: RTL and testbench
===============================

# rr_allocator

Parametrised round-robin output-port allocator for the symmetric butterfly router, one instance per output port. It decodes the flit type and destination on every input channel, grants the output to one header flit, and holds the grant for the whole packet. Rotating priority removes the starvation of fixed priority, and a packet-length cap stops one input from holding the port indefinitely. Its `sel` vector drives the output-port mux select.

## Interface
- `PORTS`, 4: number of input channels, ≥2.
- `ADR_W`, `$clog2(PORTS)`: destination field width.
- `MAX_PKT`, 15: maximum payload flits per packet, ≥1.
- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `r_adr`  in  ADR_W  this output port's address, static.
- `in_ch_hdr_msn`  in  [PORTS][ADR_W+2]  per-channel flit type in bits [ADR_W+1:ADR_W] and destination in bits [ADR_W-1:0].
- `sel`  out  PORTS  one-hot mux select, combinational; all zero when no input is selected.
- `grant`  out  1  combinational; high in the cycle a new header is granted.
- `busy`  out  1  registered; a packet holds the port.
- `owner`  out  ADR_W  registered; index of the holding input.
- `len_err`  out  1  registered one-cycle pulse; the packet was cut at `MAX_PKT`.

## Operation
- **Flit types:**
  - HEADER = 2'b11.
  - PAYLOAD = 2'b10.
  - NULL = 2'b00.
  - 2'b01 is reserved and treated as NULL.
- **Request:** `req[i]` = (type is HEADER) and (destination == `r_adr`).
- **State:** `busy`, `owner`, rotating pointer `ptr` (ADR_W bits), payload counter `cnt` ($clog2(MAX_PKT+1) bits).
- **Release condition:**
  - `rel` = `busy` and (owner's type != PAYLOAD, or `cnt` == `MAX_PKT`).
  - `arb_en` = !`busy` or `rel`.
- **Arbitration (when `arb_en`):**
  - Winner `w` is the first `i` with `req[i]`, scanning `ptr`, `ptr`+1, … mod `PORTS`.
  - `grant` = |`req`; `sel` = onehot(`w`), or zero if no request.
  - When `grant` is high, the next state is: `busy`←1, `owner`←`w`, `ptr`←(`w`+1) mod `PORTS`, `cnt`←0.
  - When `grant` is low, the next state is `busy`←0; `ptr` is unchanged.
- **Hold (`busy` and not `rel`):**
  - `sel` = onehot(`owner`); `grant` = 0.
  - `cnt`←`cnt`+1.
  - Headers on other inputs are ignored and not latched.
- **Length cap:** when `rel` is caused by `cnt` == `MAX_PKT` while owner's type is still PAYLOAD, `len_err`←1 for one cycle. That trailing payload is not forwarded.
- **Back-to-back packets:** the release cycle re-arbitrates with no bubble. The previous owner has lowest priority because `ptr` has advanced past it.
- Payload flits on a non-owner input never assert `sel`.

## Timing
- Grant latency is 0 cycles. The header passes through the mux in the cycle it appears.
- `busy`, `owner` and `len_err` reflect the grant from the following edge.
- A packet of N payload flits (N ≤ `MAX_PKT`) holds `sel` for N+1 consecutive cycles: the header plus N payloads.
- **Reset:** `busy`=0, `owner`=0, `ptr`=0, `cnt`=0, `len_err`=0. With idle inputs, `sel`=0 and `grant`=0.
- **Reset asserted mid-packet:** state clears immediately. `sel` follows the combinational arbitration of the current inputs.
- **Simultaneous release and requests:** the new winner is selected in the same cycle.
- **Simultaneous owner release and the owner's new header:** the owner may win only if no other input requests.
- **Pointer wrap:** `owner` = `PORTS`-1 sets `ptr` to 0.
- The arbitration path is combinational from `in_ch_hdr_msn` to `sel`/`grant`. There is no combinational path from input to registered outputs.

## Test plan
- **Reset, idle inputs:** all channels NULL → `sel`=0000, `grant`=0, `busy`=0 every cycle.
- **Single packet:** PORTS=4, `r_adr`=2; ch1 sends HEADER to dest 2, then 3 PAYLOAD, then NULL → `sel`=0010 for 4 cycles with `grant` only in cycle 0; `busy`=1 for cycles 1–4; `sel`=0000 after.
- **Round-robin fairness:** ch0 and ch3 send continuous 1-payload packets to `r_adr` → grants alternate 0, 3, 0, 3; neither input wins twice in a row.
- **Zero-bubble handoff:** the cycle ch1's packet ends, ch2 presents a HEADER → `sel` goes from 0010 to 0100 with no 0000 cycle; `grant`=1 in that cycle.
- **Length cap:** MAX_PKT=4; ch0 streams 6 PAYLOAD after its header → `sel`=0001 for 5 cycles; `len_err` pulses once, one cycle later; ch0's excess payloads are not selected.
- **Mid-packet reset, and non-matching traffic:**
  - Pull `rst_n` low during ch2's payload → `busy`=0 and `ptr`=0 asynchronously.
  - A header to dest ≠ `r_adr` never asserts `sel`.

Source files
------------

// File: rtl/rr_allocator.sv
// rtl/rr_allocator.sv - round-robin output-port allocator with packet hold and length cap
module rr_allocator #(
    parameter int PORTS   = 4,
    parameter int ADR_W   = $clog2(PORTS),
    parameter int MAX_PKT = 15
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [ADR_W-1:0]            r_adr,
    input  logic [PORTS-1:0][ADR_W+1:0] in_ch_hdr_msn,
    output logic [PORTS-1:0]            sel,
    output logic                        grant,
    output logic                        busy,
    output logic [ADR_W-1:0]            owner,
    output logic                        len_err
);
    localparam int               CNT_W   = $clog2(MAX_PKT + 1);
    localparam logic [1:0]       T_HDR   = 2'b11;
    localparam logic [1:0]       T_PAY   = 2'b10;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PKT);
    localparam logic [ADR_W-1:0] LAST    = ADR_W'(PORTS - 1);

    logic [ADR_W-1:0] ptr;
    logic [ADR_W-1:0] win;
    logic [ADR_W-1:0] idx_a;
    logic [ADR_W-1:0] ptr_nxt;
    logic [CNT_W-1:0] cnt;
    logic [PORTS-1:0] req;
    logic             owner_pay;
    logic             rel;
    logic             cut;
    logic             arb_en;
    int               idx;

    always_comb begin
        req = '0;
        for (int i = 0; i < PORTS; i++) begin
            req[i] = (in_ch_hdr_msn[i][ADR_W+1:ADR_W] == T_HDR) &&
                     (in_ch_hdr_msn[i][ADR_W-1:0] == r_adr);
        end
    end

    // Scan from farthest to nearest so the request closest to ptr is written last and wins.
    always_comb begin
        win   = '0;
        idx   = 0;
        idx_a = '0;
        for (int k = PORTS - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= PORTS) begin
                idx = idx - PORTS;
            end
            idx_a = ADR_W'(idx);
            if (req[idx_a]) begin
                win = idx_a;
            end
        end
    end

    assign ptr_nxt   = (win == LAST) ? '0 : win + 1'b1;
    assign owner_pay = (in_ch_hdr_msn[owner][ADR_W+1:ADR_W] == T_PAY);
    assign rel       = busy && (!owner_pay || (cnt == CNT_MAX));
    assign cut       = busy && owner_pay && (cnt == CNT_MAX);
    assign arb_en    = !busy || rel;

    always_comb begin
        sel   = '0;
        grant = 1'b0;
        if (arb_en) begin
            grant = |req;
            if (grant) begin
                sel[win] = 1'b1;
            end
        end else begin
            sel[owner] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            owner   <= '0;
            ptr     <= '0;
            cnt     <= '0;
            len_err <= 1'b0;
        end else begin
            len_err <= cut;
            if (arb_en) begin
                if (grant) begin
                    busy  <= 1'b1;
                    owner <= win;
                    ptr   <= ptr_nxt;
                    cnt   <= '0;
                end else begin
                    busy <= 1'b0;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rr_allocator.sv
// tb/tb_rr_allocator.sv - self-checking bench for rr_allocator
module tb_rr_allocator;
    localparam int P  = 4;
    localparam int A  = 2;
    localparam int MP = 4;
    localparam logic [3:0] NL = 4'b0000;
    localparam logic [3:0] PL = 4'b1010;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [A-1:0]     r_adr = 2'd2;
    logic [P-1:0][A+1:0] ch;
    logic [P-1:0]     sel;
    logic             grant;
    logic             busy;
    logic [A-1:0]     owner;
    logic             len_err;

    int errors = 0;
    int checks = 0;

    int m_busy, m_owner, m_ptr, m_fwd, m_lerr, m_win, m_esel;
    bit m_rel, m_hold;
    logic [1:0] m_otyp;
    bit [P-1:0] m_rq;

    int gsel[$];
    int ns, ne;

    rr_allocator #(.PORTS(P), .ADR_W(A), .MAX_PKT(MP)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .r_adr(r_adr),
        .in_ch_hdr_msn(ch),
        .sel(sel),
        .grant(grant),
        .busy(busy),
        .owner(owner),
        .len_err(len_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [3:0] hd(input int d);
        logic [1:0] dd;
        dd = 2'(d);
        return {2'b11, dd};
    endfunction

    task automatic cyc(input logic [3:0] c0, input logic [3:0] c1,
                       input logic [3:0] c2, input logic [3:0] c3);
        @(posedge clk);
        #1;
        ch[0] = c0;
        ch[1] = c1;
        ch[2] = c2;
        ch[3] = c3;
        #1;
    endtask

    // Packet-level reference: who holds the port, how many payloads it has forwarded.
    initial begin
        m_busy = 0; m_owner = 0; m_ptr = 0; m_fwd = 0; m_lerr = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_busy = 0; m_owner = 0; m_ptr = 0; m_fwd = 0; m_lerr = 0;
            end
            for (int i = 0; i < P; i++) begin
                m_rq[i] = (ch[i][3:2] == 2'b11) && (ch[i][1:0] == r_adr);
            end
            m_otyp = ch[m_owner][3:2];
            m_rel  = (m_busy != 0) && ((m_otyp != 2'b10) || (m_fwd == MP));
            m_hold = (m_busy != 0) && !m_rel;
            m_win  = -1;
            if (!m_hold) begin
                for (int off = 0; off < P; off++) begin
                    if (m_win < 0 && m_rq[(m_ptr + off) % P]) m_win = (m_ptr + off) % P;
                end
            end
            m_esel = m_hold ? (1 << m_owner) : ((m_win >= 0) ? (1 << m_win) : 0);
            chk("model_sel", int'(sel), m_esel);
            chk("model_grant", int'(grant), int'(m_win >= 0));
            chk("model_busy", int'(busy), m_busy);
            chk("model_owner", int'(owner), m_owner);
            chk("model_len_err", int'(len_err), m_lerr);
            if (rst_n) begin
                m_lerr = int'(m_rel && (m_otyp == 2'b10));
                if (m_hold) begin
                    m_fwd++;
                end else if (m_win >= 0) begin
                    m_busy = 1; m_owner = m_win; m_ptr = (m_win + 1) % P; m_fwd = 0;
                end else begin
                    m_busy = 0;
                end
            end
        end
    end

    initial begin
        ch = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int k = 0; k < 3; k++) begin
            cyc(NL, NL, NL, NL);
            chk("idle_sel", int'(sel), 0);
            chk("idle_grant", int'(grant), 0);
            chk("idle_busy", int'(busy), 0);
        end

        cyc(NL, hd(2), NL, NL);
        chk("sp_hdr_sel", int'(sel), 4'b0010);
        chk("sp_hdr_grant", int'(grant), 1);
        chk("sp_hdr_busy", int'(busy), 0);
        for (int k = 0; k < 3; k++) begin
            cyc(NL, PL, NL, NL);
            chk("sp_pay_sel", int'(sel), 4'b0010);
            chk("sp_pay_grant", int'(grant), 0);
            chk("sp_pay_busy", int'(busy), 1);
        end
        cyc(NL, NL, NL, NL);
        chk("sp_end_sel", int'(sel), 0);
        chk("sp_end_busy", int'(busy), 1);
        cyc(NL, NL, NL, NL);
        chk("sp_after_busy", int'(busy), 0);

        cyc(NL, hd(2), NL, NL);
        cyc(NL, PL, NL, NL);
        chk("ho_pay_sel", int'(sel), 4'b0010);
        cyc(NL, NL, hd(2), NL);
        chk("ho_sel", int'(sel), 4'b0100);
        chk("ho_grant", int'(grant), 1);
        cyc(NL, NL, PL, NL);
        cyc(NL, NL, NL, NL);

        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) cyc(hd(2), NL, NL, hd(2));
            else            cyc(PL, NL, NL, PL);
            if (grant) gsel.push_back(int'(sel));
        end
        cyc(NL, NL, NL, NL);
        chk("rr_count", gsel.size(), 4);
        if (gsel.size() == 4) begin
            chk("rr_g0", gsel[0], 4'b1000);
            chk("rr_g1", gsel[1], 4'b0001);
            chk("rr_g2", gsel[2], 4'b1000);
            chk("rr_g3", gsel[3], 4'b0001);
        end

        cyc(hd(2), NL, NL, NL);
        ns = int'(sel == 4'b0001);
        ne = 0;
        for (int k = 0; k < 6; k++) begin
            cyc(PL, NL, NL, NL);
            ns += int'(sel == 4'b0001);
            ne += int'(len_err);
            if (k == 5) chk("cap_len_err_cycle", int'(len_err), 1);
        end
        cyc(NL, NL, NL, NL);
        ne += int'(len_err);
        cyc(NL, NL, NL, NL);
        ne += int'(len_err);
        chk("cap_sel_cycles", ns, 5);
        chk("cap_len_err_pulses", ne, 1);

        cyc(NL, hd(0), 4'b0110, hd(1));
        chk("nm_sel", int'(sel), 0);
        chk("nm_grant", int'(grant), 0);
        cyc(hd(1), NL, 4'b0110, hd(3));
        chk("nm_sel2", int'(sel), 0);

        cyc(NL, NL, hd(2), NL);
        chk("rst_hdr_sel", int'(sel), 4'b0100);
        cyc(NL, NL, PL, NL);
        cyc(NL, NL, PL, NL);
        chk("rst_pre_busy", int'(busy), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_busy", int'(busy), 0);
        chk("rst_async_owner", int'(owner), 0);
        chk("rst_async_sel", int'(sel), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(NL, hd(2), NL, hd(2));
        chk("rst_ptr_zero", int'(sel), 4'b0010);
        cyc(NL, NL, NL, NL);
        cyc(NL, NL, NL, NL);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
